// File: rtl/int_pkg.sv
// Shared vector indices and winner classification for the interrupt controller
// and the CPU control unit.
package int_pkg;
  localparam int unsigned VEC_W_DEF = 6;
  localparam int unsigned RST_VEC   = 63;
  localparam int unsigned SNMI_VEC  = 62;

  typedef enum logic [1:0] {
    WIN_NONE,
    WIN_RST,
    WIN_SNMI,
    WIN_SRC
  } win_e;
endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first request finder: reports whether any request is set and the
// index of the lowest set bit.
module int_prio_enc #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     i_req,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);
  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int unsigned i = N; i > 0; i--) begin
      if (i_req[i-1]) o_idx = IDX_W'(i - 1);
    end
  end
endmodule

// File: rtl/int_priority_ctrl.sv
// Fixed-priority interrupt controller: reset > system NMI > maskable sources,
// with INTACK-edge grant, auto-clear pulses and post-grant request holdoff.
module int_priority_ctrl
  import int_pkg::*;
#(
  parameter int unsigned         NUM_SRC         = 8,
  parameter int unsigned         VEC_W           = VEC_W_DEF,
  parameter int unsigned         SRC_VEC_TOP     = 60,
  parameter logic [NUM_SRC-1:0]  SINGLE_SRC_MASK = '1,
  parameter int unsigned         HOLDOFF         = 2
) (
  input  logic               MCLK,
  input  logic               RSTn,
  input  logic               INTACK,
  input  logic               GIE,
  input  logic               Vacant,
  input  logic [NUM_SRC-1:0] src_int,
  input  logic [NUM_SRC-1:0] src_ie,
  output logic [NUM_SRC-1:0] src_clr,
  output logic               reset,
  output logic               NMI,
  output logic               INT,
  output logic               VMA_clr,
  output logic               RST_NMI_clr,
  output logic [VEC_W-1:0]   IntAddrLSBs
);
  localparam int unsigned IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned HOLD_W = $clog2(HOLDOFF + 1);

  logic               r_reset, r_snmi, r_nmi, r_int, r_ack_q;
  logic               r_vma_clr, r_rst_nmi_clr;
  logic [NUM_SRC-1:0] r_src_clr;
  logic [VEC_W-1:0]   r_vec;
  logic [IDX_W-1:0]   r_idx;
  logic [HOLD_W-1:0]  r_hold;

  logic               w_enc_valid;
  logic [IDX_W-1:0]   w_enc_idx;
  win_e               w_win;
  logic               w_grant, w_quiet;
  logic               w_snmi_nxt, w_nmi_nxt, w_int_nxt, w_rst_nxt;
  logic [VEC_W-1:0]   w_vec_nxt;
  logic [NUM_SRC-1:0] w_clr;

  int_prio_enc #(
    .N     (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_enc (
    .i_req   (src_int & src_ie & {NUM_SRC{GIE}}),
    .o_valid (w_enc_valid),
    .o_idx   (w_enc_idx)
  );

  // The granted winner is the one currently presented to the CPU.
  always_comb begin
    w_win = WIN_NONE;
    if (r_reset)    w_win = WIN_RST;
    else if (r_nmi) w_win = WIN_SNMI;
    else if (r_int) w_win = WIN_SRC;
  end

  always_comb begin
    w_grant    = INTACK && !r_ack_q && (r_hold == '0) && (w_win != WIN_NONE);
    w_quiet    = r_reset || w_grant || (r_hold != '0);
    w_snmi_nxt = (Vacant && !r_reset) || (r_snmi && !(w_grant && w_win == WIN_SNMI));
    w_nmi_nxt  = w_snmi_nxt && !w_quiet;
    w_int_nxt  = w_enc_valid && !w_quiet;
    w_rst_nxt  = r_reset && !(w_grant && w_win == WIN_RST);
    w_vec_nxt  = r_vec;
    if (w_rst_nxt)      w_vec_nxt = VEC_W'(RST_VEC);
    else if (w_nmi_nxt) w_vec_nxt = VEC_W'(SNMI_VEC);
    else if (w_int_nxt) w_vec_nxt = VEC_W'(SRC_VEC_TOP) - VEC_W'(w_enc_idx);
  end

  always_comb begin
    w_clr = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (w_grant && w_win == WIN_SRC && r_idx == IDX_W'(i)) w_clr[i] = SINGLE_SRC_MASK[i];
    end
  end

  always_ff @(posedge MCLK or negedge RSTn) begin
    if (!RSTn) begin
      r_reset       <= 1'b1;
      r_snmi        <= 1'b0;
      r_nmi         <= 1'b0;
      r_int         <= 1'b0;
      r_ack_q       <= 1'b0;
      r_vma_clr     <= 1'b0;
      r_rst_nmi_clr <= 1'b0;
      r_src_clr     <= '0;
      r_vec         <= VEC_W'(RST_VEC);
      r_idx         <= '0;
      r_hold        <= '0;
    end else begin
      r_reset       <= w_rst_nxt;
      r_snmi        <= w_snmi_nxt;
      r_nmi         <= w_nmi_nxt;
      r_int         <= w_int_nxt;
      r_ack_q       <= INTACK;
      r_vma_clr     <= w_grant && (w_win == WIN_SNMI);
      r_rst_nmi_clr <= w_grant && (w_win == WIN_SNMI || w_win == WIN_RST);
      r_src_clr     <= w_clr;
      r_vec         <= w_vec_nxt;
      if (w_int_nxt) r_idx <= w_enc_idx;
      if (w_grant)              r_hold <= HOLD_W'(HOLDOFF);
      else if (r_hold != '0)    r_hold <= r_hold - 1'b1;
    end
  end

  assign reset       = r_reset;
  assign NMI         = r_nmi;
  assign INT         = r_int;
  assign VMA_clr     = r_vma_clr;
  assign RST_NMI_clr = r_rst_nmi_clr;
  assign src_clr     = r_src_clr;
  assign IntAddrLSBs = r_vec;
endmodule

// File: tb/tb_int_priority_ctrl.sv
// Directed bench for int_priority_ctrl: reset phase, source grants, SNMI,
// GIE masking, holdoff timing and asynchronous reset abort.
module tb_int_priority_ctrl;
  logic       MCLK = 1'b0;
  logic       RSTn, INTACK, GIE, Vacant;
  logic [7:0] src_int, src_ie, src_clr;
  logic       reset, NMI, INT, VMA_clr, RST_NMI_clr;
  logic [5:0] IntAddrLSBs;

  int n_checks = 0;
  int n_fail   = 0;

  int_priority_ctrl #(
    .NUM_SRC         (8),
    .VEC_W           (6),
    .SRC_VEC_TOP     (60),
    .SINGLE_SRC_MASK (8'b1101_1111),
    .HOLDOFF         (2)
  ) dut (
    .MCLK        (MCLK),
    .RSTn        (RSTn),
    .INTACK      (INTACK),
    .GIE         (GIE),
    .Vacant      (Vacant),
    .src_int     (src_int),
    .src_ie      (src_ie),
    .src_clr     (src_clr),
    .reset       (reset),
    .NMI         (NMI),
    .INT         (INT),
    .VMA_clr     (VMA_clr),
    .RST_NMI_clr (RST_NMI_clr),
    .IntAddrLSBs (IntAddrLSBs)
  );

  always #5 MCLK = ~MCLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  initial begin
    RSTn = 1'b1; INTACK = 1'b0; GIE = 1'b0; Vacant = 1'b0;
    src_int = '0; src_ie = '0;
    #1 RSTn = 1'b0;
    #1;
    check("rst_reset",  32'(reset), 1);
    check("rst_nmi",    32'(NMI), 0);
    check("rst_int",    32'(INT), 0);
    check("rst_srcclr", 32'(src_clr), 0);
    check("rst_vmaclr", 32'(VMA_clr), 0);
    check("rst_rnclr",  32'(RST_NMI_clr), 0);
    check("rst_vec",    32'(IntAddrLSBs), 63);

    // Reset phase: Vacant ignored, reset held until first INTACK edge
    tick(); RSTn = 1'b1; Vacant = 1'b1;
    tick(); check("rph_reset1", 32'(reset), 1);
    check("rph_nmi", 32'(NMI), 0);
    Vacant = 1'b0;
    tick(); check("rph_reset2", 32'(reset), 1);
    INTACK = 1'b1;
    tick(); check("rgrant_reset", 32'(reset), 0);
    check("rgrant_rnclr", 32'(RST_NMI_clr), 1);
    check("rgrant_vec",   32'(IntAddrLSBs), 63);
    tick(); check("rgrant_rnclr_end", 32'(RST_NMI_clr), 0);
    check("rgrant_nmi", 32'(NMI), 0);
    tick(); tick(); INTACK = 1'b0;
    tick();

    // Single-source 0: grant, clear pulse, holdoff of HOLDOFF+1 cycles
    GIE = 1'b1; src_ie = 8'hFF; src_int = 8'h01;
    tick(); check("s0_int", 32'(INT), 1);
    check("s0_vec", 32'(IntAddrLSBs), 60);
    INTACK = 1'b1;
    tick(); check("s0_clr", 32'(src_clr), 8'h01);
    check("s0_int_h0", 32'(INT), 0);
    tick(); check("s0_clr_end", 32'(src_clr), 0);
    check("s0_int_h1", 32'(INT), 0);
    tick(); check("s0_int_h2", 32'(INT), 0);
    tick(); check("s0_int_back", 32'(INT), 1);
    check("s0_held_ack_noclr", 32'(src_clr), 0);
    INTACK = 1'b0; src_int = 8'h00;
    tick(); check("s0_int_drop", 32'(INT), 0);

    // Multi-source 5 (with 7 pending): no clear pulse, level re-asserts
    src_int = 8'b1010_0000;
    tick(); check("s5_int", 32'(INT), 1);
    check("s5_vec", 32'(IntAddrLSBs), 55);
    INTACK = 1'b1;
    tick(); check("s5_noclr", 32'(src_clr), 0);
    check("s5_int_h0", 32'(INT), 0);
    INTACK = 1'b0;
    tick(); check("s5_noclr2", 32'(src_clr), 0);
    tick(); check("s5_int_h2", 32'(INT), 0);
    tick(); check("s5_int_back", 32'(INT), 1);
    check("s5_vec_back", 32'(IntAddrLSBs), 55);

    // SNMI preempts pending source 5
    Vacant = 1'b1;
    tick(); check("nmi_set", 32'(NMI), 1);
    check("nmi_vec", 32'(IntAddrLSBs), 62);
    Vacant = 1'b0;
    tick(); check("nmi_flag_held", 32'(NMI), 1);
    INTACK = 1'b1;
    tick(); check("nmi_vmaclr", 32'(VMA_clr), 1);
    check("nmi_rnclr", 32'(RST_NMI_clr), 1);
    check("nmi_srcclr", 32'(src_clr), 0);
    check("nmi_forced", 32'(NMI), 0);
    INTACK = 1'b0;
    tick(); check("nmi_vmaclr_end", 32'(VMA_clr), 0);
    tick(); tick();
    check("nmi_cleared", 32'(NMI), 0);
    check("nmi_int_back", 32'(INT), 1);
    check("nmi_vec_back", 32'(IntAddrLSBs), 55);

    // GIE masks maskable sources only
    GIE = 1'b0; src_int = 8'b0000_0100;
    tick(); check("gie_int", 32'(INT), 0);
    check("gie_vec_hold", 32'(IntAddrLSBs), 55);
    Vacant = 1'b1;
    tick(); check("gie_nmi", 32'(NMI), 1);
    check("gie_nmi_vec", 32'(IntAddrLSBs), 62);
    Vacant = 1'b0;

    // Async reset right after a grant aborts pulse and holdoff
    INTACK = 1'b1;
    tick(); check("ab_vmaclr", 32'(VMA_clr), 1);
    INTACK = 1'b0;
    #2 RSTn = 1'b0;
    #1;
    check("ab_reset",  32'(reset), 1);
    check("ab_vmaclr0", 32'(VMA_clr), 0);
    check("ab_rnclr0", 32'(RST_NMI_clr), 0);
    check("ab_srcclr", 32'(src_clr), 0);
    check("ab_vec",    32'(IntAddrLSBs), 63);
    #2 RSTn = 1'b1;
    INTACK = 1'b1;
    tick(); check("ab_regrant", 32'(reset), 0);
    check("ab_regrant_rnclr", 32'(RST_NMI_clr), 1);
    INTACK = 1'b0;
    tick(); tick(); tick();

    // Spurious INTACK: no pulses and no holdoff
    INTACK = 1'b1;
    tick(); check("sp_rnclr", 32'(RST_NMI_clr), 0);
    check("sp_vmaclr", 32'(VMA_clr), 0);
    check("sp_srcclr", 32'(src_clr), 0);
    INTACK = 1'b0; Vacant = 1'b1;
    tick(); check("sp_no_holdoff", 32'(NMI), 1);
    Vacant = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
